// File: rtl/bus_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : bus_load_unit
// Description : Receiving end of the common bus. Loads the bus value into the
//               register selected by a 3-bit destination code, applies
//               per-register clear/increment controls, issues a registered
//               memory write strobe and keeps a sticky control-conflict flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_load_unit #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  bus_data,
    input  logic [2:0]        load_sel,
    input  logic [5:0]        inc_en,
    input  logic [5:0]        clr_en,
    output logic [AWIDTH-1:0] ar_q,
    output logic [AWIDTH-1:0] pc_q,
    output logic [WIDTH-1:0]  dr_q,
    output logic [WIDTH-1:0]  ac_q,
    output logic [WIDTH-1:0]  ir_q,
    output logic [WIDTH-1:0]  tr_q,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              conflict
);

    localparam logic [2:0] c_SEL_MEM = 3'd7;

    // Register index order shared by inc_en/clr_en/w_load:
    // 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR. Destination code = index + 1.
    logic [5:0]                 w_load;
    logic                       w_mem_wr;
    logic                       w_conflict;
    logic [1:0][AWIDTH-1:0]     w_addr_q;
    logic [3:0][WIDTH-1:0]      w_data_q;

    logic                       r_mem_we;
    logic [AWIDTH-1:0]          r_mem_addr;
    logic [WIDTH-1:0]           r_mem_wdata;
    logic                       r_conflict;

    // One-hot load decode from the destination code, plus conflict detect
    always_comb begin
        w_load = '0;
        for (int i = 0; i < 6; i++) begin
            w_load[i] = (load_sel == 3'(i + 1));
        end
        w_mem_wr   = (load_sel == c_SEL_MEM);
        // Clear colliding with load or increment is a control error;
        // load together with increment is legal (load wins).
        w_conflict = |(clr_en & (w_load | inc_en));
    end

    // Address-width registers (AR, PC): clear > load > increment > hold
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_addr
            logic [AWIDTH-1:0] r_q;

            // Update one address register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (clr_en[gi]) begin
                    r_q <= '0;
                end else if (w_load[gi]) begin
                    r_q <= bus_data[AWIDTH-1:0];
                end else if (inc_en[gi]) begin
                    r_q <= r_q + 1'b1;
                end
            end

            assign w_addr_q[gi] = r_q;
        end
    endgenerate

    // Data-width registers (DR, AC, IR, TR) live at register indices 2..5
    generate
        for (genvar gj = 0; gj < 4; gj++) begin : g_data
            logic [WIDTH-1:0] r_q;

            // Update one data register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= '0;
                end else if (clr_en[gj + 2]) begin
                    r_q <= '0;
                end else if (w_load[gj + 2]) begin
                    r_q <= bus_data;
                end else if (inc_en[gj + 2]) begin
                    r_q <= r_q + 1'b1;
                end
            end

            assign w_data_q[gj] = r_q;
        end
    endgenerate

    // Memory write port: address is AR as it stood before this edge, so a
    // concurrent AR update only shows up on the next write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_mem_wr;
            if (w_mem_wr) begin
                r_mem_addr  <= w_addr_q[0];
                r_mem_wdata <= bus_data;
            end
        end
    end

    // Sticky conflict flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict <= 1'b0;
        end else if (w_conflict) begin
            r_conflict <= 1'b1;
        end
    end

    assign ar_q      = w_addr_q[0];
    assign pc_q      = w_addr_q[1];
    assign dr_q      = w_data_q[0];
    assign ac_q      = w_data_q[1];
    assign ir_q      = w_data_q[2];
    assign tr_q      = w_data_q[3];
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign conflict  = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_bus_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_load_unit
// Description : Self-checking bench for bus_load_unit: directed scenarios
//               followed by random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_load_unit;

    localparam int WIDTH  = 16;
    localparam int AWIDTH = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  bus_data;
    logic [2:0]        load_sel;
    logic [5:0]        inc_en;
    logic [5:0]        clr_en;
    logic [AWIDTH-1:0] ar_q, pc_q, mem_addr;
    logic [WIDTH-1:0]  dr_q, ac_q, ir_q, tr_q, mem_wdata;
    logic              mem_we, conflict;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: registers by index 0 AR .. 5 TR
    logic [15:0] m_reg [6];
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_conf;

    bus_load_unit #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_data  (bus_data),
        .load_sel  (load_sel),
        .inc_en    (inc_en),
        .clr_en    (clr_en),
        .ar_q      (ar_q),
        .pc_q      (pc_q),
        .dr_q      (dr_q),
        .ac_q      (ac_q),
        .ir_q      (ir_q),
        .tr_q      (tr_q),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mask_of(input int i);
        return (i < 2) ? 16'h0FFF : 16'hFFFF;
    endfunction

    // Model one clock edge from the rules: rst > clear > load > increment
    task automatic model_edge();
        logic [15:0] old_ar;
        old_ar = m_reg[0];
        if (rst) begin
            for (int i = 0; i < 6; i++) m_reg[i] = '0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_conf = 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (clr_en[i] && (int'(load_sel) == i + 1 || inc_en[i]))
                    m_conf = 1'b1;
                if (clr_en[i])                  m_reg[i] = '0;
                else if (int'(load_sel) == i + 1) m_reg[i] = bus_data & mask_of(i);
                else if (inc_en[i])             m_reg[i] = (m_reg[i] + 16'd1) & mask_of(i);
            end
            m_we = (load_sel == 3'd7);
            if (m_we) begin
                m_addr  = old_ar;
                m_wdata = bus_data;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ar_q",      16'(ar_q),     m_reg[0]);
        check("pc_q",      16'(pc_q),     m_reg[1]);
        check("dr_q",      dr_q,          m_reg[2]);
        check("ac_q",      ac_q,          m_reg[3]);
        check("ir_q",      ir_q,          m_reg[4]);
        check("tr_q",      tr_q,          m_reg[5]);
        check("mem_we",    16'(mem_we),   16'(m_we));
        check("conflict",  16'(conflict), 16'(m_conf));
        if (m_we || mem_we) begin
            check("mem_addr",  16'(mem_addr), m_addr);
            check("mem_wdata", mem_wdata,     m_wdata);
        end
    endtask

    // Apply inputs, take one edge, update model, check 1 time unit later
    task automatic step(input logic r, input logic [2:0] sel, input logic [15:0] d,
                        input logic [5:0] inc, input logic [5:0] clr);
        rst = r; load_sel = sel; bus_data = d; inc_en = inc; clr_en = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 6; i++) m_reg[i] = '0;
        m_we = 0; m_addr = 0; m_wdata = 0; m_conf = 0;
        rst = 1; load_sel = 0; bus_data = 0; inc_en = 0; clr_en = 0;
        @(negedge clk);

        // Reset held with a load request pending
        step(1, 3'b001, 16'hFFFF, 6'h00, 6'h00);
        step(1, 3'b001, 16'hFFFF, 6'h00, 6'h00);
        check("rst_ar", 16'(ar_q), 16'h0000);
        check("rst_we", 16'(mem_we), 16'h0000);

        // Loads into AR (truncated) then DR
        step(0, 3'b001, 16'hABCD, 6'h00, 6'h00);
        step(0, 3'b011, 16'hABCD, 6'h00, 6'h00);
        check("ld_ar", 16'(ar_q), 16'h0BCD);
        check("ld_dr", dr_q, 16'hABCD);
        check("ld_pc_untouched", 16'(pc_q), 16'h0000);

        // Increment wrap on PC and AC
        step(0, 3'b010, 16'hFFFF, 6'h00, 6'h00);
        step(0, 3'b000, 16'h0000, 6'h02, 6'h00);
        check("pc_wrap", 16'(pc_q), 16'h0000);
        step(0, 3'b100, 16'hFFFF, 6'h00, 6'h00);
        step(0, 3'b000, 16'h0000, 6'h08, 6'h00);
        check("ac_wrap", ac_q, 16'h0000);
        check("wrap_noconf", 16'(conflict), 16'h0000);

        // Memory write uses pre-edge AR while AR increments
        step(0, 3'b001, 16'h0123, 6'h00, 6'h00);
        step(0, 3'b111, 16'h5A5A, 6'h01, 6'h00);
        check("wr_we", 16'(mem_we), 16'h0001);
        check("wr_addr", 16'(mem_addr), 16'h0123);
        check("wr_data", mem_wdata, 16'h5A5A);
        check("wr_ar", 16'(ar_q), 16'h0124);
        step(0, 3'b000, 16'h0000, 6'h00, 6'h00);
        check("wr_we_drop", 16'(mem_we), 16'h0000);
        check("wr_addr_hold", 16'(mem_addr), 16'h0123);

        // Back-to-back writes
        step(0, 3'b111, 16'h1111, 6'h00, 6'h00);
        step(0, 3'b111, 16'h2222, 6'h00, 6'h00);
        check("b2b_we", 16'(mem_we), 16'h0001);
        check("b2b_data", mem_wdata, 16'h2222);

        // Clear vs load conflict on IR, sticky until reset
        step(0, 3'b101, 16'h0042, 6'h00, 6'h10);
        check("conf_ir", ir_q, 16'h0000);
        check("conf_set", 16'(conflict), 16'h0001);
        for (int i = 0; i < 10; i++) step(0, 3'b000, 16'h0000, 6'h00, 6'h00);
        check("conf_sticky", 16'(conflict), 16'h0001);
        step(1, 3'b111, 16'hBEEF, 6'h00, 6'h00);
        check("conf_rst", 16'(conflict), 16'h0000);
        step(0, 3'b000, 16'h0000, 6'h00, 6'h00);
        check("rst_kills_wr", 16'(mem_we), 16'h0000);

        // Clear vs increment conflict
        step(0, 3'b000, 16'h0000, 6'h04, 6'h04);
        check("conf_inc", 16'(conflict), 16'h0001);
        step(1, 3'b000, 16'h0000, 6'h00, 6'h00);

        // Load+inc on PC is legal; TR increments concurrently
        step(0, 3'b110, 16'h0005, 6'h00, 6'h00);
        step(0, 3'b010, 16'h0777, 6'h22, 6'h00);
        check("ldinc_pc", 16'(pc_q), 16'h0777);
        check("ldinc_tr", tr_q, 16'h0006);
        check("ldinc_noconf", 16'(conflict), 16'h0000);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0),
                 3'($urandom_range(0, 7)),
                 16'($urandom),
                 6'($urandom),
                 ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
